phy_tx_scheduler: RTL and testbench
===================================

# phy_tx_scheduler

Round-robin scheduler sharing one byte-wide PHY transmit path (the parallel-to-serial stage fed at `clk_f`) among four byte requesters. After reset it emits a training run of idle COM characters (0xBC), then grants bursts of up to MAX_BURST bytes to one requester at a time. Each burst is framed by a header byte carrying the requester id and followed by one idle gap. It sits directly upstream of the serializer: `data_out`/`valid_out` drive the serializer's parallel data/valid inputs.

## Interface
- TRAIN_LEN, 16: idle (0xBC) cycles emitted after reset release before any grant; range 1..255.
- MAX_BURST, 8: maximum data bytes per burst; range 1..255.
- clk_f  in  1  byte clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge `clk_f`.
- req_valid  in  4  requester i has a byte available (show-ahead FIFO semantics).
- req_data  in  32  requester i byte at bits [8i+7:8i].
- tx_enable  in  1  permits new grants; does not abort a burst in progress.
- req_pop  out  4  combinational one-hot; bit i=1 consumes requester i's current byte this cycle.
- data_out  out  8  registered byte to serializer.
- valid_out  out  1  registered; 1 = header or data byte, 0 = idle (data_out=0xBC).
- cur_owner  out  2  registered id of current/last burst owner.
- busy  out  1  registered; 1 while in HDR/DATA.

## Operation
- States: TRAIN, IDLE, DATA. Registers: state, cnt (8 bit), owner (2 bit), last_owner (2 bit).
- Reset (reset=0 at an edge): state=TRAIN, cnt=0, data_out=0xBC, valid_out=0, busy=0, cur_owner=0, last_owner=3 (priority starts at requester 0). req_pop=0 while reset=0. Reset mid-burst abandons the burst immediately; no byte is popped in the reset cycle.
- TRAIN: data_out=0xBC, valid_out=0; cnt increments each cycle; when cnt==TRAIN_LEN-1 go to IDLE, cnt=0. Requests are ignored; req_pop=0.
- IDLE: if tx_enable=1 and any req_valid, select the first i with req_valid[i]=1, searching last_owner+1, +2, +3, +4 (mod 4). At that edge: owner=i, cur_owner=i, data_out=0xF0|i, valid_out=1, busy=1, cnt=0, state=DATA. No pop in IDLE. Otherwise data_out=0xBC, valid_out=0.
- DATA: req_pop[owner]=req_valid[owner] && cnt<MAX_BURST. If popping: data_out=req_data[owner], valid_out=1, cnt++. If not popping (valid low or cnt==MAX_BURST): data_out=0xBC, valid_out=0, busy=0, last_owner=owner, state=IDLE. The burst ends on the first non-pop cycle even if valid later returns.
- A header followed by zero data bytes is legal (owner valid dropped right after grant).
- A data byte equal to 0xBC or 0xF0–0xF3 is passed unmodified; framing is by valid_out only.
- tx_enable deassertion in DATA has no effect until IDLE.

## Timing
- Grant latency: request seen in IDLE at edge k → header on data_out after edge k.
- Pop at cycle k+1 (state DATA) → that byte on data_out after edge k+1. Requester must present its next byte in the cycle after a pop.
- Minimum spacing: header + N data + 1 gap = N+2 cycles per burst. The IDLE gap cycle doubles as the arbitration cycle, so back-to-back bursts have exactly one 0xBC between them.
- Full-rate: MAX_BURST bytes then forced gap, even if the owner is still valid.
- Round-robin wrap: after owner 3, search order is 0,1,2,3.
- First header after reset appears no earlier than edge TRAIN_LEN+1 after reset release.

## Test plan
- Reset/training: hold reset=0 3 cycles, release with req_valid=4'b1111 → exactly 16 cycles data_out=0xBC, valid_out=0, req_pop=0, then header 0xF0.
- Single burst: only req 2 valid with bytes 0x11,0x22,0x33, then valid low → data_out 0xF2,0x11,0x22,0x33,0xBC; valid_out 1,1,1,1,0; req_pop[2] pulses 3 cycles.
- Burst cap: req 1 always valid, MAX_BURST=8 → header 0xF1, 8 bytes, one 0xBC gap, then header 0xF1 again.
- Round-robin: all four valid continuously → headers in order 0xF0,0xF1,0xF2,0xF3,0xF0, each burst 8 bytes, one gap between bursts.
- Reset mid-burst: assert reset after 3rd data byte of req 0 → next edge valid_out=0, data_out=0xBC, req_pop=0. After release, full 16-cycle training, then first grant to req 0.
- tx_enable/empty header: tx_enable=0 with req 3 valid → no header. Raise tx_enable, drop req 3 valid the cycle after header → 0xF3 then 0xBC, no pop.

Source files
------------

// File: rtl/phy_tx_scheduler.sv
// Round-robin scheduler sharing one byte-wide PHY transmit path among four
// requesters. Emits a training run of idle COM characters after reset, then
// grants framed bursts (header byte + up to MAX_BURST data bytes + one gap).
module phy_tx_scheduler #(
  parameter int unsigned TRAIN_LEN = 16,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic        tx_enable,
  output logic [3:0]  req_pop,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic [1:0]  cur_owner,
  output logic        busy
);

  localparam logic [7:0] IdleChar  = 8'hBC;
  localparam logic [7:0] TrainLast = 8'(TRAIN_LEN - 1);
  localparam logic [7:0] MaxBurst  = 8'(MAX_BURST);

  typedef enum logic [1:0] {StTrain, StIdle, StData} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_owner_q, last_owner_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic        grant_found;
  logic [1:0]  grant_id;
  logic [1:0]  cand;
  logic        pop_en;
  logic [7:0]  owner_byte;

  // Round-robin search starting just after the last burst owner.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = 2'd0;
    cand        = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner_q + 2'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Pop the owner's byte while it has one and the burst cap is not reached;
  // suppressed during reset so an abandoned burst loses no byte.
  always_comb begin
    pop_en     = reset && (state_q == StData) && req_valid[owner_q] && (cnt_q < MaxBurst);
    req_pop    = pop_en ? (4'b0001 << owner_q) : 4'b0000;
    owner_byte = req_data[{owner_q, 3'b000} +: 8];
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    data_d       = IdleChar;
    valid_d      = 1'b0;
    busy_d       = busy_q;
    unique case (state_q)
      StTrain: begin
        busy_d = 1'b0;
        if (cnt_q == TrainLast) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StIdle: begin
        busy_d = 1'b0;
        if (tx_enable && grant_found) begin
          owner_d = grant_id;
          data_d  = {6'b111100, grant_id};
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (pop_en) begin
          data_d  = owner_byte;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          // First non-pop cycle ends the burst; this gap is also the next
          // arbitration cycle.
          busy_d       = 1'b0;
          last_owner_d = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StTrain;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_f) begin
    if (!reset) begin
      state_q      <= StTrain;
      cnt_q        <= 8'd0;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      data_q       <= IdleChar;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign cur_owner = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Directed bench for phy_tx_scheduler: requester sources are modelled as
// byte tables with read pointers; expected outputs go through a scoreboard.
module tb_phy_tx_scheduler;

  logic        clk_f = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        tx_enable;
  logic [3:0]  req_pop;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  cur_owner;
  logic        busy;

  phy_tx_scheduler #(
    .TRAIN_LEN(16),
    .MAX_BURST(8)
  ) dut (
    .clk_f     (clk_f),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .tx_enable (tx_enable),
    .req_pop   (req_pop),
    .data_out  (data_out),
    .valid_out (valid_out),
    .cur_owner (cur_owner),
    .busy      (busy)
  );

  always #5 clk_f = ~clk_f;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tab [4][64];
  int         rd [4];
  int         avail [4];
  int         enx [4];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive sources, check pop, push expectation, compare after edge.
  task automatic tick(input logic [7:0] ed, input logic ev, input logic [3:0] epop);
    logic [3:0] popped;
    exp_t       e;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = (rd[i] < avail[i]);
      req_data[i*8 +: 8]  = tab[i][rd[i] % 64];
    end
    #1;
    chk("req_pop", {4'b0, req_pop}, {4'b0, epop});
    popped = req_pop;
    sb.push_back('{d: ed, v: ev});
    @(posedge clk_f);
    #1;
    for (int i = 0; i < 4; i++) if (popped[i]) rd[i]++;
    e = sb.pop_front();
    chk("data_out", data_out, e.d);
    chk("valid_out", {7'b0, valid_out}, {7'b0, e.v});
    chk("busy", {7'b0, busy}, {7'b0, e.v});
  endtask

  task automatic gap();
    tick(8'hBC, 1'b0, 4'b0000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) gap();
  endtask

  task automatic hdr(input int o);
    tick(8'hF0 | 8'(o), 1'b1, 4'b0000);
    chk("cur_owner", {6'b0, cur_owner}, 8'(o));
  endtask

  task automatic dbytes(input int o, input int n);
    for (int k = 0; k < n; k++) begin
      tick(tab[o][enx[o]], 1'b1, 4'b0001 << o);
      enx[o]++;
    end
  endtask

  task automatic burst(input int o, input int n);
    hdr(o);
    dbytes(o, n);
    gap();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rd[i]    = 0;
      enx[i]   = 0;
      avail[i] = 20;
      for (int k = 0; k < 64; k++) tab[i][k] = 8'(8'h40 * i + k);
    end
    // Framing characters inside payload must pass through untouched.
    tab[1][10] = 8'hBC;
    tab[1][11] = 8'hF3;
    tab[0][2]  = 8'hF0;
    req_valid = 4'b0;
    req_data  = 32'b0;
    tx_enable = 1'b1;

    // Reset and training with all requesters valid.
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(16);

    // Round-robin across all four, full bursts, wrapping back to 0.
    burst(0, 8);
    burst(1, 8);
    burst(2, 8);
    burst(3, 8);
    burst(0, 8);
    for (int i = 0; i < 4; i++) avail[i] = rd[i];
    idle(1);

    // Single short burst from requester 2.
    tab[2][rd[2]]     = 8'h11;
    tab[2][rd[2] + 1] = 8'h22;
    tab[2][rd[2] + 2] = 8'h33;
    avail[2] = rd[2] + 3;
    burst(2, 3);
    idle(1);

    // Burst cap with requester 1 always valid; tx_enable drop mid-burst is ignored.
    avail[1] = rd[1] + 20;
    hdr(1);
    tx_enable = 1'b0;
    dbytes(1, 8);
    gap();
    tx_enable = 1'b1;
    burst(1, 8);
    avail[1] = rd[1];
    idle(1);

    // Reset mid-burst restores priority to requester 0 over requester 2.
    avail[0] = rd[0] + 20;
    hdr(0);
    avail[2] = rd[2] + 20;
    dbytes(0, 3);
    reset = 1'b0;
    gap();
    chk("cur_owner_rst", {6'b0, cur_owner}, 8'd0);
    reset = 1'b1;
    idle(16);
    burst(0, 8);
    avail[0] = rd[0];
    avail[2] = rd[2];
    idle(1);

    // tx_enable gating and header with zero data bytes.
    tx_enable = 1'b0;
    avail[3]  = rd[3] + 5;
    idle(3);
    tx_enable = 1'b1;
    hdr(3);
    avail[3] = rd[3];
    gap();
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
